// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Load-side bus of the 7-segment scan driver. The core (master) presents a
//   16-bit hex value plus per-digit decimal-point requests, and pulses load
//   for one cycle to have the driver capture them.
//
//   Signals:
//     value  [15:0]  hex value, value[3:0] is the rightmost digit
//     load           single-cycle capture strobe
//     dp_in  [3:0]   decimal-point request per digit, active-high
//
//   Modports:
//     master  drives value/load/dp_in (core side)
//     slave   samples value/load/dp_in (display driver side)
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;

  modport master (output value, output load, output dp_in);
  modport slave  (input  value, input  load, input  dp_in);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a 4-digit, common-anode, multiplexed 7-segment display from a
//   16-bit value captured through a one-strobe load port. Each digit is held
//   for REFRESH_CYCLES clocks; the first BLANK_CYCLES clocks of every dwell
//   keep all anodes off so the previous digit's segments cannot ghost onto
//   the next one. All outputs are registered.
//
//   Parameters:
//     REFRESH_CYCLES  clocks per digit dwell (4..262143, 18-bit counter)
//     BLANK_CYCLES    blanked clocks at the start of a dwell (1..REFRESH_CYCLES-1)
//
//   Ports:
//     clk      system clock, rising edge
//     rst      synchronous reset, active-high
//     load_if  slave side of seg7_scan_driver_if (value, load, dp_in)
//     an[3:0]  digit anodes, active-low, an[0] = rightmost digit
//     seg[6:0] segments {g,f,e,d,c,b,a}, active-low
//     dp       decimal point, active-low
//
//   Build option:
//     SEG7_LEADING_ZERO_BLANK_EN  when defined, leading zero digits (3..1)
//     without a decimal-point request stay dark during their dwell.
module seg7_scan_driver #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  seg7_scan_driver_if.slave         load_if,
  output logic [3:0]                an,
  output logic [6:0]                seg,
  output logic                      dp
);

  localparam int          CNT_W     = 18;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

  logic [15:0]      val_q,  val_d;
  logic [3:0]       dp_q,   dp_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [1:0]       idx_q,  idx_d;
  logic [3:0]       an_q,   an_d;
  logic [6:0]       seg_q,  seg_d;
  logic             dpo_q,  dpo_d;

  phase_e           phase;
  logic [3:0]       nibble;
  logic             suppress;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hexDecode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Shadow registers follow the load strobe; the last load before an edge wins.
  always_comb begin
    val_d = val_q;
    dp_d  = dp_q;
    if (load_if.load) begin
      val_d = load_if.value;
      dp_d  = load_if.dp_in;
    end
  end

  // Dwell counter; the digit index only moves when the counter wraps.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // Pick the nibble of the digit currently being scanned.
  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      2'd0: nibble = val_q[3:0];
      2'd1: nibble = val_q[7:4];
      2'd2: nibble = val_q[11:8];
      default: nibble = val_q[15:12];
    endcase
  end

  // A digit is a leading zero when it and every digit to its left are zero;
  // a requested decimal point keeps it visible. Digit 0 is always shown.
  always_comb begin
    suppress = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd1: suppress = (val_q[15:4]  == 12'h000) && !dp_q[1];
      2'd2: suppress = (val_q[15:8]  == 8'h00)   && !dp_q[2];
      2'd3: suppress = (val_q[15:12] == 4'h0)    && !dp_q[3];
      default: suppress = 1'b0;
    endcase
`endif
  end

  // Output decode from the pre-edge counter/index/shadow state, so the
  // registered outputs lag the scan state by exactly one clock.
  always_comb begin
    phase = (cnt_q < BLANK_LIM) ? PH_BLANK : PH_SHOW;
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dpo_d = 1'b1;
    if (phase == PH_SHOW && !suppress) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hexDecode(nibble);
      dpo_d = ~dp_q[idx_q];
    end
  end

  // All state, including the output registers, returns to a dark display on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      dp_q  <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dpo_q <= 1'b1;
    end else begin
      val_q <= val_d;
      dp_q  <= dp_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dpo_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Output-side counterpart to the button debouncer: it takes a 16-bit value from the core and drives a 4-digit, common-anode, multiplexed 7-segment display. Each digit is scanned in turn with a programmable dwell time and a blanking gap to suppress ghosting. The value is captured through a one-strobe load port. The block sits between the counter/control logic and the board pins.

## Interface
- REFRESH_CYCLES, 50000: clock cycles per digit dwell; legal range 4..262143; sets the scan counter width to 18 bits.
- BLANK_CYCLES, 2: cycles at the start of each dwell with all anodes off; legal range 1..REFRESH_CYCLES-1.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- value  input  16  hex value to show; value[3:0] drives digit 0 (rightmost) and value[15:12] drives digit 3.
- load  input  1  single-cycle strobe; captures value and dp_in.
- dp_in  input  4  decimal-point request per digit, active-high.
- an  output  4  digit anodes, active-low; an[0] selects digit 0.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
- Single clock domain. There is no handshake beyond load, and load is accepted on every cycle it is high.
- Shadow registers: val_q (16 bits) and dp_q (4 bits). On an edge with load=1, val_q<=value and dp_q<=dp_in. Reset clears both to 0.
- Scan counter cnt counts 0..REFRESH_CYCLES-1. At the terminal count it wraps to 0 and the digit index idx advances 0→1→2→3→0 (2-bit wrap).
- Phases within a dwell:
  - BLANK (cnt < BLANK_CYCLES): an=4'b1111, seg=7'h7F, dp=1.
  - SHOW: an has only bit idx low. seg is the hex decode of nibble idx of val_q. dp=~dp_q[idx].
- Hex decode, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- All three outputs are registered. They are computed from idx, cnt, val_q and dp_q as those registers stand before the edge.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, cnt=0, idx=0, val_q=0, dp_q=0.

## Timing
- Load latency: the load edge updates val_q, and the next edge updates seg. The new data is visible 2 edges after load is sampled, and only if the current digit is in SHOW.
- Load during SHOW changes seg mid-dwell. This is permitted; there is no frame alignment.
- Load on the same edge as a cnt wrap: val_q takes the new value, and the output for the new digit (in BLANK) is unaffected.
- Consecutive loads: the last one wins; no value is queued.
- Digit period is exactly REFRESH_CYCLES cycles. A frame is 4×REFRESH_CYCLES cycles. an is low for REFRESH_CYCLES−BLANK_CYCLES cycles per digit.
- After rst falls, edge 1 outputs BLANK for digit 0 (cnt=0). an[0] first goes low on edge BLANK_CYCLES+1.
- rst asserted mid-scan: on that edge all registers return to their reset values. Outputs go blank on the same edge.
- At most one an bit is ever low. Across an idx change, all anodes are high for at least BLANK_CYCLES cycles.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN:
  - Defined: during SHOW, digit k (k=3,2,1) keeps its anode high, with seg=7'h7F and dp=1, when nibbles k..3 of val_q are all zero and dp_q[k]=0. Digit 0 is never suppressed. Scan timing is unchanged.
  - Undefined: every digit is shown, including leading zeros.

## Test plan
- Reset check: assert rst for 3 cycles, mid-dwell on idx=2. Required: an=1111, seg=7F, dp=1 after the next edge, and digit 0 is the first to light, BLANK_CYCLES+1 edges after release.
- Decode sweep: REFRESH_CYCLES=8, BLANK_CYCLES=2, load value=16'h3210. Required: each digit is shown for 6 cycles in order 0,1,2,3. seg is 1000000, 1111001, 0100100, 0110000 on an 1110, 1101, 1011, 0111.
- Load latency: load 16'hFFFF during digit-0 SHOW. Required: seg=0001110 exactly 2 edges after load is sampled.
- Simultaneous load and wrap: load 16'h000A on the cnt terminal edge. Required: digit 1 shows 0 (1000000) and the next digit-0 dwell shows A (0001000).
- Decimal point: load dp_in=4'b0100. Required: dp=0 only while an=1011 in SHOW, and dp=1 everywhere else, including BLANK.
- Macro on: load 16'h0050 with dp_in=0. Required: an[3] and an[2] never go low, and an[1] shows 5 (0010010) and an[0] shows 0. With the macro off, all four anodes cycle.
